// File: rtl/aes_rnd_feed.sv
// Fresh-randomness feed (xorshift128) for the masked AES S-box.
// Optional reseed request counter: RND_RESEED_REQ_EN.
module aes_rnd_feed #(
  parameter int D               = 2,
  parameter int BLIND_N_RND     = 2,
  parameter int RESEED_INTERVAL = 1024
) (
  input  logic                                 ClkxCI,
  input  logic                                 RstxBI,
  input  logic [31:0]                          SeedxDI,
  input  logic                                 SeedValidxSI,
  output logic                                 SeedReadyxSO,
  input  logic                                 RunxSI,
  output logic [2*D*(D-1)-1:0]                 rnd_bus0w,
  output logic [D*(D-1)+2*BLIND_N_RND-1:0]     rnd_bus1w,
  output logic [2*D*(D-1)+4*BLIND_N_RND-1:0]   rnd_bus2w,
  output logic [4*D*(D-1)-1:0]                 rnd_bus3w,
  output logic                                 RndValidxSO,
  output logic                                 SeededxSO
`ifdef RND_RESEED_REQ_EN
  ,
  output logic                                 ReseedReqxSO
`endif
);

  localparam int W0 = 2*D*(D-1);
  localparam int W1 = D*(D-1) + 2*BLIND_N_RND;
  localparam int W2 = 2*D*(D-1) + 4*BLIND_N_RND;
  localparam int W3 = 4*D*(D-1);
  localparam int WT = W0 + W1 + W2 + W3;

  typedef enum logic [1:0] {
    S_UNSEEDED,
    S_LOAD,
    S_RUN
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_x, r_y, r_z, r_w;
  logic [1:0]  r_cnt;
  logic        r_rdy;
  logic [WT-1:0] r_bus;
  logic        r_valid;

  logic        w_hs;
  logic        w_adv;
  logic        w_last;
  logic        w_zero;
  logic [31:0] w_t;
  logic [31:0] w_wn;

  // A seed word always wins over an advance request.
  assign w_hs   = SeedValidxSI & r_rdy;
  assign w_adv  = (r_state == S_RUN) & RunxSI & ~w_hs;
  assign w_last = (r_state == S_LOAD) & w_hs & (r_cnt == 2'd3);
  assign w_zero = ~|{r_x, r_y, r_z, SeedxDI};
  assign w_t    = r_x ^ (r_x << 11);
  assign w_wn   = r_w ^ (r_w >> 19) ^ w_t ^ (w_t >> 8);

  // FSM state register
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) r_state <= S_UNSEEDED;
    else         r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_UNSEEDED: if (w_hs)   w_state_nxt = S_LOAD;
      S_LOAD:     if (w_last) w_state_nxt = S_RUN;
      S_RUN:      if (w_hs)   w_state_nxt = S_LOAD;
      default:    w_state_nxt = S_UNSEEDED;
    endcase
  end

  // Seed loading and generator advance
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      r_x   <= '0;
      r_y   <= '0;
      r_z   <= '0;
      r_w   <= '0;
      r_cnt <= '0;
    end else if (w_hs) begin
      if (r_state != S_LOAD) begin
        r_x   <= SeedxDI;
        r_cnt <= 2'd1;
      end else begin
        unique case (r_cnt)
          2'd1: begin
            r_y   <= SeedxDI;
            r_cnt <= 2'd2;
          end
          2'd2: begin
            r_z   <= SeedxDI;
            r_cnt <= 2'd3;
          end
          default: begin
            r_w   <= w_zero ? 32'h0000_0001 : SeedxDI;
            r_cnt <= 2'd0;
          end
        endcase
      end
    end else if (w_adv) begin
      r_x <= r_y;
      r_y <= r_z;
      r_z <= r_w;
      r_w <= w_wn;
    end
  end

  // Buses hold fresh bits for one cycle only, else zero
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      r_bus   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_bus   <= w_adv ? w_wn[WT-1:0] : '0;
      r_valid <= w_adv;
    end
  end

  // Ready comes up after reset and stays up
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) r_rdy <= 1'b0;
    else         r_rdy <= 1'b1;
  end

  assign SeedReadyxSO = r_rdy;
  assign SeededxSO    = (r_state == S_RUN);
  assign RndValidxSO  = r_valid;
  assign rnd_bus0w    = r_bus[W0-1:0];
  assign rnd_bus1w    = r_bus[W0+W1-1:W0];
  assign rnd_bus2w    = r_bus[W0+W1+W2-1:W0+W1];
  assign rnd_bus3w    = r_bus[WT-1:W0+W1+W2];

`ifdef RND_RESEED_REQ_EN
  localparam int CW = $clog2(RESEED_INTERVAL + 1);
  localparam logic [CW-1:0] LIM = CW'(RESEED_INTERVAL);

  logic [CW-1:0] r_acnt;

  // Saturating advance counter, cleared by a completed seed
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI)                     r_acnt <= '0;
    else if (w_last)                 r_acnt <= '0;
    else if (w_adv && r_acnt != LIM) r_acnt <= r_acnt + CW'(1);
  end

  assign ReseedReqxSO = (r_acnt == LIM);
`endif

endmodule
